serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder built around one 1-bit add cell and a carry register.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/bit_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_adder_cell.sv
// Combinational 1-bit full adder used once per clock by the serial adder.
module bit_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-add cell plus a carry flop, LSB first,
// with a start/busy/done handshake and registered sum/cout.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             bit_s;
    logic             bit_co;

    bit_adder_cell u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    assign res_next = {bit_s, res_sr[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cnt == CNT_LAST) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; sum/cout load on the final bit so done and result align
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            busy <= (state_next == ST_RUN);
            done <= (state_next == ST_DONE);
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= bit_co;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        sum  <= res_next;
                        cout <= bit_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random adds vs a+b+cin.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks;
    int errors;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands and start before an edge; leaves time at #1 after the accept edge.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                          input bit keep_start);
        @(negedge clk);
        a = ta; b = tb; cin = tcin; start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    // Count busy cycles, then check result against the arithmetic reference and the one-cycle done.
    task automatic finish_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                                input logic tcin);
        logic [W:0] ref_v;
        int n;
        ref_v = (W+1)'(ta) + (W+1)'(tb) + (W+1)'(tcin);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (done !== 1'b0) break;
            @(posedge clk);
            #1;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(ref_v[W-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(ref_v[W]));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
        check({tag, "_sum_hold"}, 32'({cout, sum}), 32'(ref_v));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        checks = 0;
        errors = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        check("reset_outputs", 32'({busy, done, cout, sum}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add, wrap, alternating patterns with carry-in, all zeros
        launch(8'h0F, 8'h01, 1'b0, 1'b0);
        finish_check("add_0f_01", 8'h0F, 8'h01, 1'b0);
        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        finish_check("wrap_ff_01", 8'hFF, 8'h01, 1'b0);
        launch(8'hAA, 8'h55, 1'b1, 1'b0);
        finish_check("aa_55_c1", 8'hAA, 8'h55, 1'b1);
        launch(8'h00, 8'h00, 1'b0, 1'b0);
        finish_check("zero", 8'h00, 8'h00, 1'b0);
        launch(8'hFF, 8'hFF, 1'b1, 1'b0);
        finish_check("max", 8'hFF, 8'hFF, 1'b1);

        // Start held high through RUN/DONE: second add only after IDLE, with operands at that edge
        launch(8'h3C, 8'h21, 1'b1, 1'b1);
        finish_check("hold_first", 8'h3C, 8'h21, 1'b1);
        a = 8'h71; b = 8'h82; cin = 1'b0;
        @(posedge clk);
        #1;
        check("hold_second_start", 32'(busy), 32'd1);
        start = 1'b0;
        finish_check("hold_second", 8'h71, 8'h82, 1'b0);

        // Asynchronous reset in the middle of RUN
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({busy, done, cout, sum}), 32'd0);
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            check("reset_no_done", 32'({busy, done}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(8'h9E, 8'h47, 1'b1, 1'b0);
        finish_check("after_reset", 8'h9E, 8'h47, 1'b1);

        // Random operands against plain arithmetic
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            launch(ra, rb, rc, 1'b0);
            finish_check("random", ra, rb, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
